// File: rtl/ssd_capture_decoder_if.sv
// ssd_capture_decoder_if
// Bundles the two-digit seven-segment display bus with the decoded results.
//
// Signals:
//   seg_in  [6:0]  segment bus, active-low, bit order {g,f,e,d,c,b,a}
//   an_in   [7:0]  anode bus, active-low (FE = ones digit, FD = tens digit)
//   value   [5:0]  last decoded binary value (tens*10 + ones)
//   valid          one-cycle pulse when value updates
//   err            one-cycle pulse on an illegal pattern or a result above 63
//   stale          level, no completed frame within the timeout window
//
// Modports:
//   master  drives the display bus and observes the decoded results
//   slave   the capture decoder: samples the bus and produces the results

interface ssd_capture_decoder_if;
    logic [6:0] seg_in;
    logic [7:0] an_in;
    logic [5:0] value;
    logic       valid;
    logic       err;
    logic       stale;

    modport master (
        output seg_in, an_in,
        input  value, valid, err, stale
    );

    modport slave (
        input  seg_in, an_in,
        output value, valid, err, stale
    );
endinterface

// File: rtl/ssd_capture_decoder.sv
// ssd_capture_decoder
// Samples the time-multiplexed segment/anode bus of a two-digit seven-segment
// display and decodes it back to the 6-bit binary value it shows. A digit is
// accepted only after SETTLE identical synchronized samples. Once both digits
// are held, the value is rebuilt as tens*10 + ones.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   ssd_capture_decoder_if.slave (seg_in, an_in in; value, valid, err, stale out)
//
// Parameters:
//   SETTLE   identical samples needed before a digit is latched (1..255)
//   TIMEOUT  cycles without a completed frame before stale asserts
//
// Optional feature:
//   Define SSD_CAP_TIMEOUT_EN to build the stale-refresh watchdog. Without it
//   stale is tied low and no counter exists.

module ssd_capture_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 2000000
) (
    input logic                   clk,
    input logic                   rst,
    ssd_capture_decoder_if.slave  bus
);

    if (SETTLE < 1 || SETTLE > 255) begin : g_settle_range
        $error("ssd_capture_decoder: SETTLE must be in 1..255");
    end
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("ssd_capture_decoder: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {SEL_NONE, SEL_ONES, SEL_TENS} sel_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_LATCH, ST_HOLD} state_t;

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    logic [6:0] seg_m, seg_s;
    logic [7:0] an_m, an_s;
    sel_t       sel, ref_sel, ref_sel_next;
    logic [6:0] ref_seg, ref_seg_next;
    logic [7:0] cnt, cnt_next;
    state_t     state, state_next;
    logic       same;
    logic       start_digit;
    logic [4:0] decoded;
    logic [3:0] ones_r, tens_r;
    logic       have_ones, have_tens;
    logic [6:0] sum;
    logic       frame_done, latch_bad, frame_ok, frame_bad;
    logic [5:0] value_r;
    logic       valid_r, err_r;

    // Exact-match decode of an active-low segment code. Bit 4 marks a legal
    // code; bits 3:0 carry the digit.
    function automatic logic [4:0] decode(input logic [6:0] code);
        logic [4:0] res;
        res = 5'b0_0000;
        case (code)
            7'h40: res = {1'b1, 4'd0};
            7'h79: res = {1'b1, 4'd1};
            7'h24: res = {1'b1, 4'd2};
            7'h30: res = {1'b1, 4'd3};
            7'h19: res = {1'b1, 4'd4};
            7'h12: res = {1'b1, 4'd5};
            7'h02: res = {1'b1, 4'd6};
            7'h78: res = {1'b1, 4'd7};
            7'h00: res = {1'b1, 4'd8};
            7'h10: res = {1'b1, 4'd9};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // Two-flop synchronizers for the externally driven bus. They reset to
    // all ones, which reads as a blanked display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m <= '1;
            seg_s <= '1;
            an_m  <= '1;
            an_s  <= '1;
        end else begin
            seg_m <= bus.seg_in;
            seg_s <= seg_m;
            an_m  <= bus.an_in;
            an_s  <= an_m;
        end
    end

    // Only a single active anode on one of the two digit positions selects a
    // digit; blanking and multi-anode patterns are treated as no digit.
    always_comb begin
        sel = SEL_NONE;
        if (an_s == 8'hFE) begin
            sel = SEL_ONES;
        end else if (an_s == 8'hFD) begin
            sel = SEL_TENS;
        end
    end

    assign same = (sel == ref_sel) && (seg_s == ref_seg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ref_sel <= SEL_NONE;
            ref_seg <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ref_sel <= ref_sel_next;
            ref_seg <= ref_seg_next;
        end
    end

    // Debounce FSM. start_digit restarts the stability count on a new
    // (select, segments) reference; with SETTLE of 1 that first sample is
    // already enough, so LATCH is entered directly.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        ref_sel_next = ref_sel;
        ref_seg_next = ref_seg;
        start_digit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel != SEL_NONE) begin
                    start_digit = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (sel == SEL_NONE) begin
                    state_next = ST_IDLE;
                end else if (same) begin
                    cnt_next = cnt + 8'd1;
                    if (cnt_next == SETTLE_CNT) begin
                        state_next = ST_LATCH;
                    end
                end else begin
                    start_digit = 1'b1;
                end
            end
            ST_LATCH: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (sel == SEL_NONE) begin
                    state_next = ST_IDLE;
                end else if (!same) begin
                    start_digit = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (start_digit) begin
            ref_sel_next = sel;
            ref_seg_next = seg_s;
            cnt_next     = 8'd1;
            state_next   = (SETTLE_CNT == 8'd1) ? ST_LATCH : ST_SETTLE;
        end
    end

    assign decoded    = decode(ref_seg);
    assign sum        = 7'(tens_r) * 7'd10 + 7'(ones_r);
    assign frame_done = have_ones && have_tens;
    assign latch_bad  = (state == ST_LATCH) && !decoded[4];
    assign frame_ok   = frame_done && (sum <= 7'd63) && !latch_bad;
    assign frame_bad  = frame_done && (sum > 7'd63);

    // Digit storage and frame assembly. A frame consumes both have flags;
    // the LATCH update is applied after it so a newly latched digit is
    // never lost to a frame clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_r    <= '0;
            tens_r    <= '0;
            have_ones <= 1'b0;
            have_tens <= 1'b0;
            value_r   <= '0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            valid_r <= frame_ok;
            err_r   <= frame_bad || latch_bad;
            if (frame_ok) begin
                value_r <= sum[5:0];
            end
            if (frame_done) begin
                have_ones <= 1'b0;
                have_tens <= 1'b0;
            end
            if (state == ST_LATCH) begin
                if (!decoded[4]) begin
                    have_ones <= 1'b0;
                    have_tens <= 1'b0;
                end else if (ref_sel == SEL_ONES) begin
                    ones_r    <= decoded[3:0];
                    have_ones <= 1'b1;
                end else begin
                    tens_r    <= decoded[3:0];
                    have_tens <= 1'b1;
                end
            end
        end
    end

    assign bus.value = value_r;
    assign bus.valid = valid_r;
    assign bus.err   = err_r;

`ifdef SSD_CAP_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);
    logic [31:0] idle_cnt;

    // Watchdog: counts cycles since the last good frame and saturates at
    // TIMEOUT. It clears on the same edge that raises valid, so stale drops
    // in the cycle the new value appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (frame_ok) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT_CNT) begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign bus.stale = (idle_cnt == TIMEOUT_CNT);
`else
    assign bus.stale = 1'b0;
`endif

endmodule

// File: tb/tb_ssd_capture_decoder.sv
// tb_ssd_capture_decoder
// Directed bench for ssd_capture_decoder (SETTLE=4, TIMEOUT=100). It drives
// the display bus through the interface's signals and checks value, valid,
// err and stale against hand-computed values.

module tb_ssd_capture_decoder;

    logic clk = 1'b0;
    logic rst;

    int checks      = 0;
    int errors      = 0;
    int valid_count = 0;
    int err_count   = 0;
    int valid_base  = 0;
    int err_base    = 0;

    ssd_capture_decoder_if bus_if();

    ssd_capture_decoder #(
        .SETTLE  (4),
        .TIMEOUT (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.valid) valid_count++;
            if (bus_if.err) err_count++;
            if (bus_if.valid || bus_if.err) begin
                checks++;
                assert (!(bus_if.valid && bus_if.err)) else begin
                    errors++;
                    $error("[TB] FAIL valid_err_exclusive observed=%0b%0b expected=not both", bus_if.valid, bus_if.err);
                end
            end
        end
    end

    // Runaway guard; the directed sequence needs only a few hundred cycles.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Holds one bus pattern for a number of cycles, then steps 1 ns past the
    // last rising edge so outputs can be read safely.
    task automatic applyStimulus(input logic [7:0] an, input logic [6:0] seg, input int cycles);
        bus_if.an_in  = an;
        bus_if.seg_in = seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        valid_base = valid_count;
        err_base   = err_count;
    endtask

    initial begin
        logic exp_stale;
`ifdef SSD_CAP_TIMEOUT_EN
        exp_stale = 1'b1;
`else
        exp_stale = 1'b0;
`endif
        rst           = 1'b1;
        bus_if.an_in  = 8'hFF;
        bus_if.seg_in = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_value", 32'(bus_if.value), 32'd0);
        checkOutput("reset_valid", 32'(bus_if.valid), 32'd0);
        checkOutput("reset_err", 32'(bus_if.err), 32'd0);
        checkOutput("reset_stale", 32'(bus_if.stale), 32'd0);
        rst = 1'b0;
        applyStimulus(8'hFF, 7'h7F, 5);

        $display("[TB] tens 4 then ones 2");
        mark();
        applyStimulus(8'hFD, 7'h19, 10);
        applyStimulus(8'hFE, 7'h24, 7);
        checkOutput("t42_not_yet", 32'(bus_if.valid), 32'd0);
        applyStimulus(8'hFE, 7'h24, 1);
        checkOutput("t42_valid_edge", 32'(bus_if.valid), 32'd1);
        checkOutput("t42_value", 32'(bus_if.value), 32'd42);
        checkOutput("t42_err", 32'(bus_if.err), 32'd0);
        applyStimulus(8'hFE, 7'h24, 2);
        applyStimulus(8'hFF, 7'h7F, 10);
        checkOutput("t42_valid_count", 32'(valid_count - valid_base), 32'd1);
        checkOutput("t42_err_count", 32'(err_count - err_base), 32'd0);

        $display("[TB] glitch inside ones window");
        mark();
        applyStimulus(8'hFD, 7'h79, 10);
        applyStimulus(8'hFE, 7'h24, 3);
        applyStimulus(8'hFE, 7'h00, 1);
        applyStimulus(8'hFE, 7'h24, 7);
        checkOutput("glitch_not_yet", 32'(bus_if.valid), 32'd0);
        applyStimulus(8'hFE, 7'h24, 1);
        checkOutput("glitch_valid_edge", 32'(bus_if.valid), 32'd1);
        checkOutput("glitch_value", 32'(bus_if.value), 32'd12);
        applyStimulus(8'hFF, 7'h7F, 10);
        checkOutput("glitch_valid_count", 32'(valid_count - valid_base), 32'd1);
        checkOutput("glitch_err_count", 32'(err_count - err_base), 32'd0);

        $display("[TB] 50 then overflow 64");
        mark();
        applyStimulus(8'hFD, 7'h12, 10);
        applyStimulus(8'hFE, 7'h40, 10);
        applyStimulus(8'hFF, 7'h7F, 5);
        checkOutput("v50_value", 32'(bus_if.value), 32'd50);
        checkOutput("v50_valid_count", 32'(valid_count - valid_base), 32'd1);
        mark();
        applyStimulus(8'hFD, 7'h02, 10);
        applyStimulus(8'hFE, 7'h19, 10);
        applyStimulus(8'hFF, 7'h7F, 5);
        checkOutput("v64_err_count", 32'(err_count - err_base), 32'd1);
        checkOutput("v64_valid_count", 32'(valid_count - valid_base), 32'd0);
        checkOutput("v64_value_kept", 32'(bus_if.value), 32'd50);

        $display("[TB] illegal code then 13");
        mark();
        applyStimulus(8'hFE, 7'h7F, 10);
        applyStimulus(8'hFF, 7'h7F, 5);
        checkOutput("illegal_err_count", 32'(err_count - err_base), 32'd1);
        checkOutput("illegal_valid_count", 32'(valid_count - valid_base), 32'd0);
        mark();
        applyStimulus(8'hFD, 7'h79, 10);
        applyStimulus(8'hFE, 7'h30, 10);
        applyStimulus(8'hFF, 7'h7F, 5);
        checkOutput("v13_value", 32'(bus_if.value), 32'd13);
        checkOutput("v13_valid_count", 32'(valid_count - valid_base), 32'd1);
        checkOutput("v13_err_count", 32'(err_count - err_base), 32'd0);

        $display("[TB] multi-anode and blanked bus");
        mark();
        applyStimulus(8'hF0, 7'h00, 20);
        applyStimulus(8'hFF, 7'h24, 20);
        checkOutput("none_valid_count", 32'(valid_count - valid_base), 32'd0);
        checkOutput("none_err_count", 32'(err_count - err_base), 32'd0);
        checkOutput("none_value", 32'(bus_if.value), 32'd13);

        $display("[TB] tens overwritten before ones");
        mark();
        applyStimulus(8'hFD, 7'h19, 10);
        applyStimulus(8'hFF, 7'h7F, 5);
        applyStimulus(8'hFD, 7'h24, 10);
        applyStimulus(8'hFE, 7'h79, 10);
        applyStimulus(8'hFF, 7'h7F, 5);
        checkOutput("overwrite_value", 32'(bus_if.value), 32'd21);
        checkOutput("overwrite_valid_count", 32'(valid_count - valid_base), 32'd1);
        checkOutput("overwrite_err_count", 32'(err_count - err_base), 32'd0);

        $display("[TB] largest legal value 63");
        mark();
        applyStimulus(8'hFD, 7'h02, 10);
        applyStimulus(8'hFE, 7'h30, 10);
        applyStimulus(8'hFF, 7'h7F, 5);
        checkOutput("v63_value", 32'(bus_if.value), 32'd63);
        checkOutput("v63_valid_count", 32'(valid_count - valid_base), 32'd1);
        checkOutput("v63_err_count", 32'(err_count - err_base), 32'd0);

        $display("[TB] reset during settle");
        applyStimulus(8'hFD, 7'h12, 4);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_value", 32'(bus_if.value), 32'd0);
        checkOutput("midrst_valid", 32'(bus_if.valid), 32'd0);
        checkOutput("midrst_err", 32'(bus_if.err), 32'd0);
        checkOutput("midrst_stale", 32'(bus_if.stale), 32'd0);
        bus_if.an_in  = 8'hFF;
        bus_if.seg_in = 7'h7F;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mark();
        applyStimulus(8'hFE, 7'h40, 10);
        applyStimulus(8'hFF, 7'h7F, 10);
        checkOutput("midrst_partial_dropped", 32'(valid_count - valid_base), 32'd0);
        applyStimulus(8'hFD, 7'h79, 10);
        applyStimulus(8'hFF, 7'h7F, 5);
        checkOutput("v10_value", 32'(bus_if.value), 32'd10);
        checkOutput("v10_valid_count", 32'(valid_count - valid_base), 32'd1);

        $display("[TB] idle bus, then value 7");
        applyStimulus(8'hFF, 7'h7F, 120);
        checkOutput("idle_stale", 32'(bus_if.stale), 32'(exp_stale));
        applyStimulus(8'hFD, 7'h40, 10);
        applyStimulus(8'hFE, 7'h78, 7);
        checkOutput("v7_not_yet", 32'(bus_if.valid), 32'd0);
        applyStimulus(8'hFE, 7'h78, 1);
        checkOutput("v7_valid_edge", 32'(bus_if.valid), 32'd1);
        checkOutput("v7_value", 32'(bus_if.value), 32'd7);
        checkOutput("v7_stale_cleared", 32'(bus_if.stale), 32'd0);
        applyStimulus(8'hFF, 7'h7F, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
